fifo_wr_gen: RTL and testbench
==============================

Name: fifo_wr_gen

Overview:
- Parametrised FIFO write-side traffic generator; next generation of the team's fixed 8-bit incrementing FIFO writer.
- Waits for a synchronised FIFO-empty indication, then writes a burst until almost_full or a programmed burst length is reached.
- Data sequence continues across bursts. Adds an enable control, a burst-done strobe, a beat counter and sticky overflow detection.
- Sits in the write clock domain beside the FIFO IP; feeds the FIFO write port.

Parameters:
- DATA_W, 8, width of fifo_wr_data.
- MAX_VAL, 254, last value of the incrementing sequence before wrap to 0; must be < 2**DATA_W.
- BURST_LEN, 0, beats per burst; 0 = unlimited (stop only on almost_full).
- CNT_W, 16, width of beat_cnt.

Ports:
- wr_clk  in  1  write-domain clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  generator run enable
- empty  in  1  FIFO empty flag; asynchronous to wr_clk (read-domain flag)
- almost_full  in  1  FIFO almost-full flag, wr_clk domain
- full  in  1  FIFO full flag, wr_clk domain
- wr_rst_busy  in  1  FIFO write-side reset in progress
- fifo_wr_en  out  1  FIFO write enable (registered)
- fifo_wr_data  out  DATA_W  FIFO write data (registered)
- burst_done  out  1  one-cycle pulse at end of each burst
- busy  out  1  high while in WRITE state
- overflow_err  out  1  sticky: write issued while full=1
- beat_cnt  out  CNT_W  total beats written since reset, saturating

Behaviour:
- Reset (rst=1, asynchronous):
  - All outputs 0.
  - State IDLE.
  - empty synchronisers = 0.
  - Burst counter = 0.
- empty synchronisation: two-flop synchroniser giving empty_s. Controller uses only empty_s, so empty has 2-cycle latency.
- FSM states: IDLE, WAIT_EMPTY, WRITE.
  - IDLE -> WAIT_EMPTY when enable=1 and wr_rst_busy=0.
  - WAIT_EMPTY -> WRITE when empty_s=1. fifo_wr_en rises on the same clock edge as the transition.
  - WRITE -> WAIT_EMPTY when almost_full=1, or when (BURST_LEN≠0 and the current beat is beat number BURST_LEN of the burst). fifo_wr_en falls on that edge.
    - The beat presented in the cycle almost_full is sampled high is still written.
    - almost_full taking effect on the same edge as the last counted beat still yields a single burst_done.
  - Any state -> IDLE when enable=0 or wr_rst_busy=1. fifo_wr_en=0 from the next edge; burst counter cleared; no burst_done.
  - wr_rst_busy has priority over every other condition.
- Data sequence:
  - fifo_wr_data advances on every edge where fifo_wr_en=1: +1, wrapping MAX_VAL -> 0.
  - Held while fifo_wr_en=0, including across bursts and IDLE. Cleared only by rst.
  - First beat after reset carries 0.
- burst_done: registered pulse, high for exactly one cycle after the edge that leaves WRITE for WAIT_EMPTY.
- busy = (state==WRITE), registered, same timing as fifo_wr_en.
- beat_cnt: +1 per cycle with fifo_wr_en=1; saturates at all-ones.
- overflow_err: set on any cycle where fifo_wr_en=1 and full=1. Cleared only by rst.
- Sampling: almost_full and full are sampled synchronously; no internal synchronisation.

Optional Feature:
- Macro FIFO_WR_GEN_LFSR_EN.
- Defined:
  - Adds input mode (1 bit).
  - mode=1: fifo_wr_data is a Fibonacci LFSR, seeded with 1 at reset, advancing under the same conditions as the counter. Taps are x^8+x^6+x^5+x^4+1 for DATA_W=8; for other widths, the maximal-length taps from a localparam table.
  - mode=0: incrementing counter.
  - mode is sampled only in IDLE or WAIT_EMPTY; changes during WRITE are ignored until the burst ends.
- Undefined: no mode port; counter only.

Test Plan:
- Reset mid-burst: assert rst while fifo_wr_en=1 -> all outputs 0 immediately; after release, first write carries 0.
- Basic flow: enable=1, empty=1, BURST_LEN=0 -> fifo_wr_en rises 3 edges after empty rises (2 sync + 1 register); data 0,1,2,…; drive almost_full at data=10 -> data 10 written, fifo_wr_en=0 next cycle, burst_done pulses once.
- Wrap and continuation:
  - MAX_VAL=254 -> sequence 253, 254, 0, 1.
  - Second burst after empty re-asserts resumes from the held value, not 0.
- Burst length: BURST_LEN=16, almost_full=0 -> exactly 16 beats per burst, burst_done once per burst, beat_cnt=32 after two bursts.
- Reset-busy / enable: raise wr_rst_busy mid-burst -> fifo_wr_en=0 next cycle, no burst_done, data held. Same check with enable=0.
- Overflow: force full=1 during WRITE -> overflow_err=1 and stays 1 after full drops. LFSR build: mode=1 -> sequence 01, 02, 04, 08 … matches the reference model.

Source files
------------

// File: rtl/fifo_wr_gen.sv
// FIFO write-side traffic generator: waits for a synchronised empty flag, then writes an
// incrementing (or, with FIFO_WR_GEN_LFSR_EN defined, optionally LFSR) burst into the FIFO.
module fifo_wr_gen #(
  parameter int DATA_W    = 8,
  parameter int MAX_VAL   = 254,
  parameter int BURST_LEN = 0,
  parameter int CNT_W     = 16
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  input  logic              almost_full,
  input  logic              full,
  input  logic              wr_rst_busy,
`ifdef FIFO_WR_GEN_LFSR_EN
  input  logic              mode,
`endif
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              burst_done,
  output logic              busy,
  output logic              overflow_err,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;
  localparam logic [DATA_W-1:0] MAXV = DATA_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, WAIT_EMPTY, WRITE} state_t;

  state_t            state_q, state_d;
  logic              empty_meta_q, empty_s_q;
  logic              wr_en_q, wr_en_d;
  logic              burst_done_q, burst_done_d;
  logic              ovf_q, ovf_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              cnt_adv, last_beat;

  // empty comes from the read domain: two flops before the controller sees it
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      empty_meta_q <= 1'b0;
      empty_s_q    <= 1'b0;
    end else begin
      empty_meta_q <= empty;
      empty_s_q    <= empty_meta_q;
    end
  end

  // burst_cnt_q holds beats already written in this burst; current beat is burst_cnt_q+1
  assign last_beat = (BURST_LEN != 0) && (burst_cnt_q == BW'(BURST_LEN - 1));

  always_comb begin
    state_d = state_q;
    if (wr_rst_busy || !enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       state_d = WAIT_EMPTY;
        WAIT_EMPTY: if (empty_s_q) state_d = WRITE;
        WRITE:      if (almost_full || last_beat) state_d = WAIT_EMPTY;
        default:    state_d = IDLE;
      endcase
    end
    wr_en_d      = (state_d == WRITE);
    burst_done_d = (state_q == WRITE) && (state_d == WAIT_EMPTY);
    burst_cnt_d  = '0;
    if (state_d == WRITE && wr_en_q) burst_cnt_d = burst_cnt_q + BW'(1);
    beat_cnt_d   = beat_cnt_q;
    if (wr_en_q && beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CNT_W'(1);
    ovf_d        = ovf_q | (wr_en_q & full);
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      burst_done_q <= 1'b0;
      burst_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      burst_done_q <= burst_done_d;
      burst_cnt_q  <= burst_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef FIFO_WR_GEN_LFSR_EN
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:  return 32'h0000_0003;
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      24: return 32'h00E1_0000;
      32: return 32'h8020_0003;
      default: return 32'h3 << (w - 2);
    endcase
  endfunction

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic              mode_q;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;

  // mode is frozen for the whole burst; only the selected sequence advances
  always_comb begin
    cnt_adv = wr_en_q && !mode_q;
    lfsr_d  = lfsr_q;
    if (wr_en_q && mode_q) lfsr_d = {lfsr_q[DATA_W-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      lfsr_q <= DATA_W'(1);
    end else begin
      if (state_q != WRITE) mode_q <= mode;
      lfsr_q <= lfsr_d;
    end
  end

  assign fifo_wr_data = mode_q ? lfsr_q : cnt_q;
`else
  assign cnt_adv      = wr_en_q;
  assign fifo_wr_data = cnt_q;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_adv) cnt_d = (cnt_q == MAXV) ? '0 : cnt_q + DATA_W'(1);
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign fifo_wr_en   = wr_en_q;
  assign busy         = wr_en_q;
  assign burst_done   = burst_done_q;
  assign overflow_err = ovf_q;
  assign beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Scoreboard bench for fifo_wr_gen: one unlimited-burst instance and one BURST_LEN=16 instance.
module tb_fifo_wr_gen;
  logic        clk = 1'b0;
  logic        rst, en0, en1, empty, af, full, wrb;
  logic        wr_en0, bd0, busy0, ovf0, wr_en1, bd1, busy1, ovf1;
  logic [7:0]  data0, data1;
  logic [15:0] bc0, bc1;
`ifdef FIFO_WR_GEN_LFSR_EN
  logic        mode;
`endif

  int total = 0;
  int bad   = 0;
  int bd0_cnt = 0;
  int bd1_cnt = 0;
  int run1 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  fifo_wr_gen #(.DATA_W(8), .MAX_VAL(254), .BURST_LEN(0), .CNT_W(16)) u_dut (
    .wr_clk(clk), .rst(rst), .enable(en0), .empty(empty), .almost_full(af), .full(full),
    .wr_rst_busy(wrb),
`ifdef FIFO_WR_GEN_LFSR_EN
    .mode(mode),
`endif
    .fifo_wr_en(wr_en0), .fifo_wr_data(data0), .burst_done(bd0), .busy(busy0),
    .overflow_err(ovf0), .beat_cnt(bc0));

  fifo_wr_gen #(.DATA_W(8), .MAX_VAL(254), .BURST_LEN(16), .CNT_W(16)) u_bl (
    .wr_clk(clk), .rst(rst), .enable(en1), .empty(empty), .almost_full(af), .full(full),
    .wr_rst_busy(wrb),
`ifdef FIFO_WR_GEN_LFSR_EN
    .mode(1'b0),
`endif
    .fifo_wr_en(wr_en1), .fifo_wr_data(data1), .burst_done(bd1), .busy(busy1),
    .overflow_err(ovf1), .beat_cnt(bc1));

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  // monitors: pop the expected beat whenever a write is presented
  always @(negedge clk) begin
    if (bd0) bd0_cnt++;
    if (!rst && wr_en0) begin
      if (q0.size() == 0) chk("sb0_unexpected_write", longint'(data0), -1);
      else chk("sb0_data", longint'(data0), longint'(q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (bd1) bd1_cnt++;
    if (!rst && wr_en1) begin
      run1++;
      if (q1.size() == 0) chk("sb1_unexpected_write", longint'(data1), -1);
      else chk("sb1_data", longint'(data1), longint'(q1.pop_front()));
    end else if (run1 != 0) begin
      chk("sb1_burst_beats", run1, 16);
      run1 = 0;
    end
  end

  task automatic wait_en(input int u);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if ((u == 0) ? wr_en0 : wr_en1) return;
    end
    chk("wait_wr_en_timeout", 0, 1);
  endtask

  task automatic wait_data(input int u, input logic [7:0] v);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (u == 0 && wr_en0 && data0 == v) return;
      if (u == 1 && wr_en1 && data1 == v) return;
    end
    chk("wait_data_timeout", 0, longint'(v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; empty = 1'b0; af = 1'b0; full = 1'b0; wrb = 1'b0;
`ifdef FIFO_WR_GEN_LFSR_EN
    mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en0, 0);
    chk("rst_data", data0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_burst_done", bd0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_beat_cnt", bc0, 0);

    // basic flow: 3-edge latency, data 0..10, almost_full at 10
    rst = 1'b0; en0 = 1'b1;
    repeat (3) @(negedge clk);
    for (int v = 0; v <= 10; v++) q0.push_back(8'(v));
    empty = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (wr_en0) begin n = i; break; end
    end
    chk("fill_latency", n, 3);
    chk("busy_in_write", busy0, 1);
    empty = 1'b0;
    wait_data(0, 8'd10);
    af = 1'b1;
    @(negedge clk);
    chk("af_stop_wr_en", wr_en0, 0);
    chk("af_burst_done", bd0, 1);
    chk("af_data_advanced", data0, 11);
    af = 1'b0;
    @(negedge clk);
    chk("burst_done_single", bd0, 0);
    chk("beat_cnt_b1", bc0, 11);
    chk("bd_count_b1", bd0_cnt, 1);

    // continuation from 11 and wrap 253,254,0,1,2
    for (int v = 11; v <= 254; v++) q0.push_back(8'(v));
    for (int v = 0; v <= 2; v++) q0.push_back(8'(v));
    empty = 1'b1;
    wait_en(0);
    empty = 1'b0;
    wait_data(0, 8'd2);
    af = 1'b1;
    @(negedge clk);
    af = 1'b0;
    chk("wrap_stop", wr_en0, 0);
    repeat (2) @(negedge clk);
    chk("beat_cnt_b2", bc0, 258);
    chk("sb0_drained_b2", q0.size(), 0);
    chk("bd_count_b2", bd0_cnt, 2);

    // wr_rst_busy mid-burst
    for (int v = 3; v <= 6; v++) q0.push_back(8'(v));
    empty = 1'b1;
    wait_en(0);
    empty = 1'b0;
    wait_data(0, 8'd6);
    wrb = 1'b1;
    @(negedge clk);
    chk("wrb_wr_en", wr_en0, 0);
    chk("wrb_no_done", bd0, 0);
    chk("wrb_busy", busy0, 0);
    repeat (3) @(negedge clk);
    chk("wrb_data_held", data0, 7);
    chk("wrb_bd_count", bd0_cnt, 2);
    wrb = 1'b0;
    repeat (2) @(negedge clk);

    // enable drop mid-burst
    for (int v = 7; v <= 9; v++) q0.push_back(8'(v));
    empty = 1'b1;
    wait_en(0);
    empty = 1'b0;
    wait_data(0, 8'd9);
    en0 = 1'b0;
    @(negedge clk);
    chk("en_wr_en", wr_en0, 0);
    chk("en_no_done", bd0, 0);
    repeat (3) @(negedge clk);
    chk("en_data_held", data0, 10);
    chk("en_bd_count", bd0_cnt, 2);
    en0 = 1'b1;
    repeat (2) @(negedge clk);

    // overflow: full during a write, sticky afterwards
    for (int v = 10; v <= 13; v++) q0.push_back(8'(v));
    empty = 1'b1;
    wait_en(0);
    empty = 1'b0;
    chk("ovf_before", ovf0, 0);
    full = 1'b1;
    @(posedge clk); #1;
    full = 1'b0;
    chk("ovf_set", ovf0, 1);
    wait_data(0, 8'd13);
    af = 1'b1;
    @(negedge clk);
    af = 1'b0;
    chk("ovf_sticky", ovf0, 1);
    chk("beat_cnt_b5", bc0, 269);

    // reset mid-burst, then restart from 0
    for (int v = 14; v <= 20; v++) q0.push_back(8'(v));
    empty = 1'b1;
    wait_en(0);
    empty = 1'b0;
    wait_data(0, 8'd16);
    rst = 1'b1;
    #1;
    chk("rstmid_wr_en", wr_en0, 0);
    chk("rstmid_data", data0, 0);
    chk("rstmid_busy", busy0, 0);
    chk("rstmid_ovf", ovf0, 0);
    chk("rstmid_beat_cnt", bc0, 0);
    repeat (2) @(negedge clk);
    q0.delete();
    rst = 1'b0;
    for (int v = 0; v <= 2; v++) q0.push_back(8'(v));
    repeat (2) @(negedge clk);
    empty = 1'b1;
    wait_en(0);
    empty = 1'b0;
    wait_data(0, 8'd2);
    af = 1'b1;
    @(negedge clk);
    af = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_beat_cnt", bc0, 3);
    chk("sb0_drained_rst", q0.size(), 0);

    // BURST_LEN=16: two back-to-back bursts
    en0 = 1'b0; en1 = 1'b1;
    for (int v = 0; v <= 31; v++) q1.push_back(8'(v));
    repeat (2) @(negedge clk);
    empty = 1'b1;
    for (int i = 0; i < 100 && bd1_cnt < 1; i++) @(negedge clk);
    empty = 1'b0;
    for (int i = 0; i < 100 && bd1_cnt < 2; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("bl_bd_count", bd1_cnt, 2);
    chk("bl_beat_cnt", bc1, 32);
    chk("bl_idle_wr_en", wr_en1, 0);
    chk("sb1_drained", q1.size(), 0);

    // almost_full together with the 16th beat: still one burst_done
    for (int v = 32; v <= 47; v++) q1.push_back(8'(v));
    empty = 1'b1;
    wait_en(1);
    empty = 1'b0;
    wait_data(1, 8'd47);
    af = 1'b1;
    @(negedge clk);
    af = 1'b0;
    repeat (3) @(negedge clk);
    chk("bl_af_bd_count", bd1_cnt, 3);
    chk("bl_af_beat_cnt", bc1, 48);
    chk("sb1_drained_af", q1.size(), 0);

`ifdef FIFO_WR_GEN_LFSR_EN
    en1 = 1'b0; en0 = 1'b1; mode = 1'b1;
    q0.push_back(8'h01); q0.push_back(8'h02); q0.push_back(8'h04);
    q0.push_back(8'h08); q0.push_back(8'h11);
    repeat (3) @(negedge clk);
    empty = 1'b1;
    wait_en(0);
    empty = 1'b0;
    wait_data(0, 8'h11);
    af = 1'b1;
    @(negedge clk);
    af = 1'b0;
    repeat (2) @(negedge clk);
    chk("lfsr_beat_cnt", bc0, 8);
    chk("sb0_drained_lfsr", q0.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
